// File: rtl/wb_pipe_to_classic.sv
// -----------------------------------------------------------------------------
// wb_pipe_to_classic
//
// Bridges a Wishbone pipelined-mode master (typically a skid buffer) onto a
// Wishbone classic-mode target. Only one request is outstanding at a time:
// the request is captured in IDLE, presented with C_STB held until the target
// terminates, and the termination is returned upstream as a registered
// single-cycle pulse.
//
// Parameters
//   AddressWidth  - address bits
//   DataWidth     - data bits (8/16/32/64)
//   Granularity   - bits per byte-select lane (SELWidth = DataWidth/Granularity)
//   TimeoutCycles - watchdog limit in BUSY cycles (timeout build only)
//
// Build option
//   WB_P2C_TIMEOUT_EN - when defined, a watchdog aborts a transfer the target
//                       never terminates and reports it upstream as P_ERR.
//
// Ports
//   CLK, RST                      clock, synchronous active-low reset
//   P_CYC/P_STB/P_WE/P_ADDR/
//   P_DAT_W/P_SEL                 pipelined-side request (in)
//   P_STALL/P_ACK/P_ERR/P_RTY/
//   P_DAT_R                       pipelined-side stall and termination (out)
//   C_CYC/C_STB/C_WE/C_ADDR/
//   C_DAT_W/C_SEL                 classic-side request (out)
//   C_ACK/C_ERR/C_RTY/C_DAT_R     classic-side termination (in)
// -----------------------------------------------------------------------------
module wb_pipe_to_classic #(
  parameter int  AddressWidth  = 16,
  parameter int  DataWidth     = 8,
  parameter int  Granularity   = 8,
  parameter int  TimeoutCycles = 255,
  localparam int SELWidth      = DataWidth / Granularity
) (
  input  logic                    CLK,
  input  logic                    RST,
  // pipelined side
  input  logic                    P_CYC,
  input  logic                    P_STB,
  input  logic                    P_WE,
  input  logic [AddressWidth-1:0] P_ADDR,
  input  logic [DataWidth-1:0]    P_DAT_W,
  input  logic [SELWidth-1:0]     P_SEL,
  output logic                    P_STALL,
  output logic                    P_ACK,
  output logic                    P_ERR,
  output logic                    P_RTY,
  output logic [DataWidth-1:0]    P_DAT_R,
  // classic side
  output logic                    C_CYC,
  output logic                    C_STB,
  output logic                    C_WE,
  output logic [AddressWidth-1:0] C_ADDR,
  output logic [DataWidth-1:0]    C_DAT_W,
  output logic [SELWidth-1:0]     C_SEL,
  input  logic                    C_ACK,
  input  logic                    C_ERR,
  input  logic                    C_RTY,
  input  logic [DataWidth-1:0]    C_DAT_R
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state, state_next;

  logic accept;     // request captured this cycle
  logic term;       // target terminated the outstanding request
  logic timeout;    // watchdog expired (always 0 without the watchdog)
  logic p_cyc_q;    // P_CYC delayed one cycle, keeps C_CYC up between transfers
  logic busy;

  assign busy = (state == BUSY);

`ifdef WB_P2C_TIMEOUT_EN
  localparam int CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

  logic [CntWidth-1:0] wd_cnt;

  // Counts BUSY cycles without termination; the cycle in which the count
  // would reach TimeoutCycles is the last one the target is given.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (busy && !term) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  logic wd_hit;
  assign wd_hit = (wd_cnt == TimeoutLast);
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: state elements are written with <= so every flop samples the values
  // from before the edge; a blocking = here would leak same-edge updates into
  // later statements and break the register semantics.
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    term       = 1'b0;
    timeout    = 1'b0;
    P_STALL    = busy;
    C_STB      = busy;
    C_CYC      = p_cyc_q | busy;

    unique case (state)
      IDLE: begin
        // target terminations are meaningless here and are not looked at
        if (P_CYC && P_STB) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // An upstream abort wins over a same-cycle termination: the master
        // has abandoned the cycle and must not see a response for it.
        if (!P_CYC) begin
          state_next = IDLE;
        end else if (C_ACK || C_ERR || C_RTY) begin
          term       = 1'b1;
          state_next = IDLE;
        end
`ifdef WB_P2C_TIMEOUT_EN
        else if (wd_hit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture, upstream termination and data return
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset along with the control so that the
  // classic bus and P_DAT_R show defined values straight out of reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      p_cyc_q <= 1'b0;
      C_WE    <= 1'b0;
      C_ADDR  <= '0;
      C_DAT_W <= '0;
      C_SEL   <= '0;
      P_ACK   <= 1'b0;
      P_ERR   <= 1'b0;
      P_RTY   <= 1'b0;
      P_DAT_R <= '0;
    end else begin
      // A timeout forces C_CYC low for the P_ERR cycle even if the master
      // still holds P_CYC.
      p_cyc_q <= P_CYC && !timeout;
      P_ACK   <= 1'b0;
      P_ERR   <= 1'b0;
      P_RTY   <= 1'b0;

      if (accept) begin
        C_WE    <= P_WE;
        C_ADDR  <= P_ADDR;
        C_DAT_W <= P_DAT_W;
        C_SEL   <= P_SEL;
      end

      if (term) begin
        // ERR > RTY > ACK so exactly one upstream termination fires
        P_ERR   <= C_ERR;
        P_RTY   <= !C_ERR && C_RTY;
        P_ACK   <= !C_ERR && !C_RTY && C_ACK;
        P_DAT_R <= C_DAT_R;
      end

      if (timeout) begin
        P_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_pipe_to_classic.sv
// -----------------------------------------------------------------------------
// tb_wb_pipe_to_classic
//
// Directed and randomized checks of the pipelined-to-classic Wishbone bridge.
// A small reference model predicts, per transfer, which single upstream
// termination must appear (ERR over RTY over ACK), when it appears, and what
// P_DAT_R must show; the bench plays the classic target itself.
// -----------------------------------------------------------------------------
module tb_wb_pipe_to_classic;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SW = 1;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          P_CYC, P_STB, P_WE;
  logic [AW-1:0] P_ADDR;
  logic [DW-1:0] P_DAT_W;
  logic [SW-1:0] P_SEL;
  logic          P_STALL, P_ACK, P_ERR, P_RTY;
  logic [DW-1:0] P_DAT_R;
  logic          C_CYC, C_STB, C_WE;
  logic [AW-1:0] C_ADDR;
  logic [DW-1:0] C_DAT_W;
  logic [SW-1:0] C_SEL;
  logic          C_ACK, C_ERR, C_RTY;
  logic [DW-1:0] C_DAT_R;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] last_rdata;   // value P_DAT_R must be holding

  wb_pipe_to_classic #(
    .AddressWidth (AW),
    .DataWidth    (DW),
    .Granularity  (8),
    .TimeoutCycles(TO)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .P_CYC  (P_CYC),
    .P_STB  (P_STB),
    .P_WE   (P_WE),
    .P_ADDR (P_ADDR),
    .P_DAT_W(P_DAT_W),
    .P_SEL  (P_SEL),
    .P_STALL(P_STALL),
    .P_ACK  (P_ACK),
    .P_ERR  (P_ERR),
    .P_RTY  (P_RTY),
    .P_DAT_R(P_DAT_R),
    .C_CYC  (C_CYC),
    .C_STB  (C_STB),
    .C_WE   (C_WE),
    .C_ADDR (C_ADDR),
    .C_DAT_W(C_DAT_W),
    .C_SEL  (C_SEL),
    .C_ACK  (C_ACK),
    .C_ERR  (C_ERR),
    .C_RTY  (C_RTY),
    .C_DAT_R(C_DAT_R)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference rule: of the terminations the target raises together, only the
  // highest-priority one reaches upstream. mask = {err, rty, ack}.
  function automatic logic [2:0] expected_term(input logic [2:0] mask);
    if (mask[2])      return 3'b100;
    else if (mask[1]) return 3'b010;
    else if (mask[0]) return 3'b001;
    else              return 3'b000;
  endfunction

  // checks made in every BUSY cycle: request presented and frozen
  task automatic check_req(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    check("busy_stb",   C_STB, 1'b1);
    check("busy_cyc",   C_CYC, 1'b1);
    check("busy_stall", P_STALL, 1'b1);
    check("busy_we",    C_WE, we);
    check("busy_addr",  C_ADDR, addr);
    check("busy_datw",  C_DAT_W, dat);
    check("busy_sel",   C_SEL, sel);
    check("busy_noterm", {P_ERR, P_RTY, P_ACK}, 3'b000);
    check("busy_datr_hold", P_DAT_R, last_rdata);
  endtask

  // One complete transfer. Returns in the response cycle (state IDLE) without
  // advancing, so the caller may present the next request in that very cycle.
  task automatic xfer(input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                      input int waits, input logic [2:0] mask,
                      input logic [DW-1:0] rdata);
    P_CYC = 1'b1; P_STB = 1'b1;
    P_WE = we; P_ADDR = addr; P_DAT_W = dat; P_SEL = sel;
    tick();
    // scramble the upstream fields: the classic side must keep the captured copy
    P_STB = 1'b0;
    P_WE = 1'($urandom); P_ADDR = AW'($urandom); P_DAT_W = DW'($urandom);
    P_SEL = SW'($urandom);
    for (int w = 0; w < waits; w++) begin
      check_req(we, addr, dat, sel);
      C_DAT_R = DW'($urandom);
      tick();
    end
    check_req(we, addr, dat, sel);
    {C_ERR, C_RTY, C_ACK} = mask;
    C_DAT_R = rdata;
    tick();
    {C_ERR, C_RTY, C_ACK} = 3'b000;
    C_DAT_R = DW'($urandom);
    check("resp_term",  {P_ERR, P_RTY, P_ACK}, expected_term(mask));
    check("resp_datr",  P_DAT_R, rdata);
    check("resp_stb",   C_STB, 1'b0);
    check("resp_stall", P_STALL, 1'b0);
    check("resp_cyc",   C_CYC, 1'b1);
    last_rdata = rdata;
  endtask

  initial begin
    RST = 1'b0;
    P_CYC = 1'b0; P_STB = 1'b0; P_WE = 1'b0;
    P_ADDR = '0; P_DAT_W = '0; P_SEL = '0;
    C_ACK = 1'b0; C_ERR = 1'b0; C_RTY = 1'b0; C_DAT_R = '0;
    last_rdata = '0;

    // ---- reset state
    tick(); tick();
    check("rst_cyc",   C_CYC, 1'b0);
    check("rst_stb",   C_STB, 1'b0);
    check("rst_stall", P_STALL, 1'b0);
    check("rst_term",  {P_ERR, P_RTY, P_ACK}, 3'b000);
    check("rst_fields", {C_WE, C_ADDR, C_DAT_W, C_SEL}, '0);
    check("rst_datr",  P_DAT_R, '0);
    RST = 1'b1;
    tick();
    check("stall_after_release", P_STALL, 1'b0);

    // ---- write, two wait states, ACK
    xfer(1'b1, 16'h1234, 8'hA5, 1'b1, 2, 3'b001, 8'h3C);
    tick();
    check("ack_single_pulse", {P_ERR, P_RTY, P_ACK}, 3'b000);
    check("datr_holds", P_DAT_R, 8'h3C);

    // ---- zero-wait read, next request accepted in the P_ACK cycle
    xfer(1'b0, 16'h0010, 8'h00, 1'b1, 0, 3'b001, 8'h5A);
    xfer(1'b1, 16'h0020, 8'h77, 1'b1, 1, 3'b001, 8'h11);

    // ---- simultaneous terminations
    xfer(1'b0, 16'h0100, 8'h00, 1'b1, 0, 3'b101, 8'hE1);
    xfer(1'b0, 16'h0200, 8'h00, 1'b1, 1, 3'b011, 8'hE2);
    xfer(1'b0, 16'h0300, 8'h00, 1'b1, 2, 3'b111, 8'hE3);
    xfer(1'b0, 16'h0400, 8'h00, 1'b1, 0, 3'b010, 8'hE4);

    // ---- randomized transfers, chained or separated by a released cycle
    for (int i = 0; i < 24; i++) begin
      xfer(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom),
           int'($urandom_range(3, 0)), 3'($urandom_range(7, 1)), DW'($urandom));
      if ($urandom_range(1, 0) == 0) begin
        P_CYC = 1'b0;
        tick();
        check("gap_cyc_low", C_CYC, 1'b0);
        check("gap_noterm", {P_ERR, P_RTY, P_ACK}, 3'b000);
      end
    end

    // ---- abort in the second BUSY cycle
    P_CYC = 1'b1; P_STB = 1'b1; P_WE = 1'b1; P_ADDR = 16'hBEEF; P_DAT_W = 8'h42; P_SEL = 1'b1;
    tick();
    P_STB = 1'b0;
    tick();
    check("abort_pre_stb", C_STB, 1'b1);
    P_CYC = 1'b0;
    tick();
    check("abort_cyc",   C_CYC, 1'b0);
    check("abort_stb",   C_STB, 1'b0);
    check("abort_stall", P_STALL, 1'b0);
    check("abort_noterm", {P_ERR, P_RTY, P_ACK}, 3'b000);
    C_ACK = 1'b1;     // late target ACK while IDLE must be ignored
    tick();
    C_ACK = 1'b0;
    check("idle_ack_ignored", {P_ERR, P_RTY, P_ACK}, 3'b000);
    tick();
    check("idle_ack_ignored2", {P_ERR, P_RTY, P_ACK}, 3'b000);
    check("abort_datr_hold", P_DAT_R, last_rdata);

    // ---- reset pulse during BUSY
    P_CYC = 1'b1; P_STB = 1'b1; P_WE = 1'b1; P_ADDR = 16'hCAFE; P_DAT_W = 8'h99; P_SEL = 1'b1;
    tick();
    P_STB = 1'b0;
    check("prereset_stb", C_STB, 1'b1);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    check("midrst_cyc",   C_CYC, 1'b0);
    check("midrst_stb",   C_STB, 1'b0);
    check("midrst_stall", P_STALL, 1'b0);
    check("midrst_term",  {P_ERR, P_RTY, P_ACK}, 3'b000);
    check("midrst_fields", {C_WE, C_ADDR, C_DAT_W, C_SEL}, '0);
    check("midrst_datr",  P_DAT_R, '0);
    last_rdata = '0;
    C_ACK = 1'b1;
    tick();
    C_ACK = 1'b0;
    check("postrst_noterm", {P_ERR, P_RTY, P_ACK}, 3'b000);
    check("postrst_stb", C_STB, 1'b0);
    tick();
    check("postrst_noterm2", {P_ERR, P_RTY, P_ACK}, 3'b000);
    P_CYC = 1'b0;
    tick();

    // ---- recovery after reset
    xfer(1'b0, 16'h0ABC, 8'h00, 1'b1, 1, 3'b001, 8'h6D);

    // ---- silent target
    P_CYC = 1'b1; P_STB = 1'b1; P_WE = 1'b0; P_ADDR = 16'h0F0F; P_DAT_W = 8'h00; P_SEL = 1'b1;
    tick();
    P_STB = 1'b0;
`ifdef WB_P2C_TIMEOUT_EN
    for (int c = 0; c < TO - 1; c++) begin
      check("wd_stb_high", C_STB, 1'b1);
      check("wd_noterm", {P_ERR, P_RTY, P_ACK}, 3'b000);
      tick();
    end
    check("wd_last_stb", C_STB, 1'b1);
    tick();
    check("wd_err_pulse", {P_ERR, P_RTY, P_ACK}, 3'b100);
    check("wd_stb_low", C_STB, 1'b0);
    check("wd_cyc_low", C_CYC, 1'b0);
    tick();
    check("wd_err_single", {P_ERR, P_RTY, P_ACK}, 3'b000);
    P_CYC = 1'b0;
    tick();
`else
    for (int c = 0; c < 100; c++) begin
      check("silent_stb_high", C_STB, 1'b1);
      tick();
    end
    check("silent_noterm", {P_ERR, P_RTY, P_ACK}, 3'b000);
    check("silent_stall", P_STALL, 1'b1);
    P_CYC = 1'b0;
    tick();
    check("silent_abort_stb", C_STB, 1'b0);
    check("silent_abort_noterm", {P_ERR, P_RTY, P_ACK}, 3'b000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
